rd_resp_merge: RTL and testbench
================================

Name: rd_resp_merge

Overview:
- Return-path companion to the read-request address switch. Merges read responses from the two downstream master ports (m0 = addr MSB 0, m1 = addr MSB 1) back onto the single upstream slave port.
- Responses are returned in original request-issue order.
- An order FIFO records the target port of every accepted request. The head entry selects which downstream response port may drain into a registered output stage.

Parameters:
- DWIDTH, 32, read data width.
- ORDER_DEPTH, 8, max outstanding requests tracked; power of 2, >= 2.
- CNT_W, $clog2(ORDER_DEPTH)+1, width of the occupancy count (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- issue_valid  input  1  upstream request accepted this cycle (req && !fifo_full on the request side).
- issue_sel  input  1  target port of the issued request (addr[AWIDTH-1]).
- order_full  output  1  order FIFO full; ORed into the upstream fifo_full.
- outstanding  output  CNT_W  order FIFO occupancy.
- m0_resp_valid  input  1  response valid from port 0.
- m0_resp_data  input  DWIDTH  response data from port 0.
- m0_resp_ready  output  1  response accept to port 0.
- m1_resp_valid  input  1  response valid from port 1.
- m1_resp_data  input  DWIDTH  response data from port 1.
- m1_resp_ready  output  1  response accept to port 1.
- s0_resp_valid  output  1  merged response valid.
- s0_resp_data  output  DWIDTH  merged response data.
- s0_resp_ready  input  1  upstream accepts response.
- err_unexpected  output  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- While rst=1 at a clock edge: wr/rd pointers=0, count=0, s0_resp_valid=0, s0_resp_data=0, err_unexpected=0, per-port counters=0.
- Reset mid-operation discards all outstanding entries and any held output.
- Order FIFO:
  - push = issue_valid && !order_full; stores issue_sel.
  - order_full = (count == ORDER_DEPTH), computed from the registered count.
  - A push attempted while full is ignored, even when a pop occurs in the same cycle.
  - Pointers are log2(ORDER_DEPTH) bits and wrap naturally.
  - Simultaneous push and pop with count not full: count unchanged, both pointers advance.
  - empty = (count == 0); outstanding = count.
- Output stage:
  - load_en = !s0_resp_valid || s0_resp_ready.
  - m0_resp_ready = !empty && head==0 && load_en.
  - m1_resp_ready = !empty && head==1 && load_en.
  - The non-head port is always held with ready=0.
  - On a handshake on port X: s0_resp_data <= mX_resp_data, s0_resp_valid <= 1, FIFO pops.
  - Otherwise, if s0_resp_ready=1: s0_resp_valid <= 0, and s0_resp_data holds its value.
- Latency: one cycle from the mX handshake to s0_resp_valid.
- Throughput: one response per cycle while s0_resp_ready=1 and the head port is valid.
- Held output: s0_resp_data is stable while s0_resp_valid && !s0_resp_ready.
- A response arriving on a port while the FIFO is empty is not accepted (ready=0).

Optional Feature:
- Macro: RD_RESP_ERR_CHECK_EN.
- Defined:
  - Per-port outstanding counters (CNT_W bits) increment on push to that port and decrement on pop from that port.
  - err_unexpected sets when mX_resp_valid=1 while the port-X counter is 0.
  - The flag stays set until rst.
- Undefined: no counters; err_unexpected tied 0.

Test Plan:
- Issue sel=0,1,0; m1 responds with 0xB1 before m0 responds with 0xA0, then m0 with 0xA2 -> s0 outputs 0xA0, 0xB1, 0xA2 in that order; m1_resp_ready=0 until 0xA0 is popped.
- 8 back-to-back issues with no responses -> order_full=1 and outstanding=8 after the 8th; a 9th issue is ignored; pop plus issue in the same cycle at full -> outstanding=7 next cycle.
- s0_resp_ready=0 for 3 cycles with m0 valid and data 0x55 -> s0_resp_data holds 0x55, m0_resp_ready=0; ready=1 -> next response appears the following cycle.
- Streaming 20 alternating requests with ready always 1 -> one response per cycle, correct order, pointers wrap past 7 with no loss.
- rst asserted with 3 outstanding and s0_resp_valid=1 -> next cycle all outputs 0, outstanding=0, both readies 0.
- With RD_RESP_ERR_CHECK_EN defined: m1_resp_valid=1 with no m1 outstanding -> err_unexpected=1 next cycle and held until rst; with the macro undefined it stays 0.

Source files
------------

// File: rtl/rd_resp_merge.sv
// Read-response merge: returns downstream m0/m1 responses upstream in request-issue order.
// Optional sticky unexpected-response detection is enabled with `define RD_RESP_ERR_CHECK_EN.
module rd_resp_merge #(
    parameter  int DWIDTH      = 32,
    parameter  int ORDER_DEPTH = 8,
    localparam int CNT_W       = $clog2(ORDER_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_sel,
    output logic              order_full,
    output logic [CNT_W-1:0]  outstanding,
    input  logic              m0_resp_valid,
    input  logic [DWIDTH-1:0] m0_resp_data,
    output logic              m0_resp_ready,
    input  logic              m1_resp_valid,
    input  logic [DWIDTH-1:0] m1_resp_data,
    output logic              m1_resp_ready,
    output logic              s0_resp_valid,
    output logic [DWIDTH-1:0] s0_resp_data,
    input  logic              s0_resp_ready,
    output logic              err_unexpected
);

    localparam int PTR_W = $clog2(ORDER_DEPTH);

    logic             order_mem [ORDER_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic head;
    logic load_en;
    logic push;
    logic m0_hs;
    logic m1_hs;
    logic pop;

    assign empty       = (count == '0);
    assign order_full  = (count == CNT_W'(ORDER_DEPTH));
    assign outstanding = count;
    assign head        = order_mem[rd_ptr];

    // A full FIFO refuses the push even if a pop frees a slot in the same cycle.
    assign push = issue_valid && !order_full;

    assign load_en       = !s0_resp_valid || s0_resp_ready;
    assign m0_resp_ready = !empty && !head && load_en;
    assign m1_resp_ready = !empty &&  head && load_en;

    assign m0_hs = m0_resp_valid && m0_resp_ready;
    assign m1_hs = m1_resp_valid && m1_resp_ready;
    assign pop   = m0_hs || m1_hs;

    // NOTE: the order storage has no reset; an entry is only read after it is written,
    // and leaving it unreset keeps it a plain register file / RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            order_mem[wr_ptr] <= issue_sel;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_resp_valid <= 1'b0;
            s0_resp_data  <= '0;
        end else if (m0_hs) begin
            s0_resp_valid <= 1'b1;
            s0_resp_data  <= m0_resp_data;
        end else if (m1_hs) begin
            s0_resp_valid <= 1'b1;
            s0_resp_data  <= m1_resp_data;
        end else if (s0_resp_ready) begin
            s0_resp_valid <= 1'b0;
        end
    end

`ifdef RD_RESP_ERR_CHECK_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0  <= '0;
            cnt1  <= '0;
            err_q <= 1'b0;
        end else begin
            case ({push && !issue_sel, m0_hs})
                2'b10:   cnt0 <= cnt0 + CNT_W'(1);
                2'b01:   cnt0 <= cnt0 - CNT_W'(1);
                default: cnt0 <= cnt0;
            endcase
            case ({push && issue_sel, m1_hs})
                2'b10:   cnt1 <= cnt1 + CNT_W'(1);
                2'b01:   cnt1 <= cnt1 - CNT_W'(1);
                default: cnt1 <= cnt1;
            endcase
            // Sticky until reset: a port presented a response it was never asked for.
            if ((m0_resp_valid && cnt0 == '0) || (m1_resp_valid && cnt1 == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_unexpected = err_q;
`else
    assign err_unexpected = 1'b0;
`endif

endmodule

// File: tb/tb_rd_resp_merge.sv
// Directed self-checking bench for rd_resp_merge: ordering, full handling, hold, streaming, reset.
module tb_rd_resp_merge;

    localparam int DWIDTH      = 32;
    localparam int ORDER_DEPTH = 8;
    localparam int CNT_W       = $clog2(ORDER_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid;
    logic              issue_sel;
    logic              order_full;
    logic [CNT_W-1:0]  outstanding;
    logic              m0_resp_valid;
    logic [DWIDTH-1:0] m0_resp_data;
    logic              m0_resp_ready;
    logic              m1_resp_valid;
    logic [DWIDTH-1:0] m1_resp_data;
    logic              m1_resp_ready;
    logic              s0_resp_valid;
    logic [DWIDTH-1:0] s0_resp_data;
    logic              s0_resp_ready;
    logic              err_unexpected;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rd_resp_merge #(.DWIDTH(DWIDTH), .ORDER_DEPTH(ORDER_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_sel      (issue_sel),
        .order_full     (order_full),
        .outstanding    (outstanding),
        .m0_resp_valid  (m0_resp_valid),
        .m0_resp_data   (m0_resp_data),
        .m0_resp_ready  (m0_resp_ready),
        .m1_resp_valid  (m1_resp_valid),
        .m1_resp_data   (m1_resp_data),
        .m1_resp_ready  (m1_resp_ready),
        .s0_resp_valid  (s0_resp_valid),
        .s0_resp_data   (s0_resp_data),
        .s0_resp_ready  (s0_resp_ready),
        .err_unexpected (err_unexpected)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge and land 1 time unit after it, away from the sampling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic err_exp;
    logic [DWIDTH-1:0] exp_d;
    logic [6:0] drain_sel;

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_sel = 1'b0;
        m0_resp_valid = 1'b0; m0_resp_data = '0;
        m1_resp_valid = 1'b0; m1_resp_data = '0;
        s0_resp_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_s0_valid", s0_resp_valid, 0);
        check("rst_s0_data",  s0_resp_data, 0);
        check("rst_outst",    outstanding, 0);
        check("rst_full",     order_full, 0);
        check("rst_m0_ready", m0_resp_ready, 0);
        check("rst_m1_ready", m1_resp_ready, 0);
        check("rst_err",      err_unexpected, 0);

        // Ordering: issue 0,1,0; m1 answers first but must wait for m0.
        issue_valid = 1'b1;
        issue_sel = 1'b0; tick();
        issue_sel = 1'b1; tick();
        issue_sel = 1'b0; tick();
        issue_valid = 1'b0;
        check("ord_outst3", outstanding, 3);
        m1_resp_valid = 1'b1; m1_resp_data = 32'hB1;
        settle();
        check("ord_m1_blocked", m1_resp_ready, 0);
        tick();
        check("ord_no_out", s0_resp_valid, 0);
        check("ord_m1_still_blocked", m1_resp_ready, 0);
        m0_resp_valid = 1'b1; m0_resp_data = 32'hA0;
        settle();
        check("ord_m0_ready", m0_resp_ready, 1);
        tick();
        m0_resp_valid = 1'b0;
        check("ord_a0_valid", s0_resp_valid, 1);
        check("ord_a0_data",  s0_resp_data, 32'hA0);
        check("ord_outst2",   outstanding, 2);
        settle();
        check("ord_m1_ready", m1_resp_ready, 1);
        check("ord_m0_not_head", m0_resp_ready, 0);
        tick();
        m1_resp_valid = 1'b0;
        check("ord_b1_data", s0_resp_data, 32'hB1);
        m0_resp_valid = 1'b1; m0_resp_data = 32'hA2;
        tick();
        m0_resp_valid = 1'b0;
        check("ord_a2_data", s0_resp_data, 32'hA2);
        check("ord_outst0",  outstanding, 0);
        tick();
        check("ord_valid_drop", s0_resp_valid, 0);
        check("ord_data_hold",  s0_resp_data, 32'hA2);

        // Fill to full, overflow attempt, then pop+issue at full.
        issue_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue_sel = i[0];
            tick();
        end
        check("full_outst8", outstanding, 8);
        check("full_flag",   order_full, 1);
        issue_sel = 1'b1;
        tick();
        check("full_ignore9", outstanding, 8);
        m0_resp_valid = 1'b1; m0_resp_data = 32'h11;
        settle();
        check("full_m0_ready", m0_resp_ready, 1);
        tick();
        issue_valid = 1'b0;
        m0_resp_valid = 1'b0;
        check("full_pop_push_outst", outstanding, 7);
        check("full_flag_clear",     order_full, 0);
        check("full_pop_data",       s0_resp_data, 32'h11);
        // Remaining order is 1,0,1,0,1,0,1; both ports always offer.
        drain_sel = 7'b1010101;
        m0_resp_valid = 1'b1; m0_resp_data = 32'hC0;
        m1_resp_valid = 1'b1; m1_resp_data = 32'hC1;
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_d = drain_sel[i] ? 32'hC1 : 32'hC0;
            check("drain_data", s0_resp_data, 64'(exp_d));
        end
        m0_resp_valid = 1'b0; m1_resp_valid = 1'b0;
        check("drain_outst0", outstanding, 0);
        tick();

        // Backpressure hold.
        issue_valid = 1'b1; issue_sel = 1'b0;
        tick(); tick();
        issue_valid = 1'b0;
        m0_resp_valid = 1'b1; m0_resp_data = 32'h55;
        tick();
        check("hold_first", s0_resp_data, 32'h55);
        s0_resp_ready = 1'b0;
        m0_resp_data = 32'h66;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold_m0_ready", m0_resp_ready, 0);
            tick();
            check("hold_valid", s0_resp_valid, 1);
            check("hold_data",  s0_resp_data, 32'h55);
        end
        check("hold_outst", outstanding, 1);
        s0_resp_ready = 1'b1;
        settle();
        check("hold_release_ready", m0_resp_ready, 1);
        tick();
        m0_resp_valid = 1'b0;
        check("hold_next_data", s0_resp_data, 32'h66);
        tick();
        check("hold_drop", s0_resp_valid, 0);

        // Streaming 20 alternating requests, each answered the cycle after issue.
        for (int c = 0; c <= 20; c++) begin
            issue_valid = (c < 20);
            issue_sel = c[0];
            m0_resp_valid = 1'b0; m1_resp_valid = 1'b0;
            if (c >= 1) begin
                if ((c - 1) % 2 == 0) begin
                    m0_resp_valid = 1'b1; m0_resp_data = 32'h100 + 32'(c - 1);
                end else begin
                    m1_resp_valid = 1'b1; m1_resp_data = 32'h100 + 32'(c - 1);
                end
                settle();
                check("stream_ready", m0_resp_ready | m1_resp_ready, 1);
            end
            tick();
            if (c >= 1) begin
                check("stream_valid", s0_resp_valid, 1);
                check("stream_data",  s0_resp_data, 64'(32'h100 + 32'(c - 1)));
            end
        end
        issue_valid = 1'b0; m0_resp_valid = 1'b0; m1_resp_valid = 1'b0;
        check("stream_outst0", outstanding, 0);
        tick();

        // Reset mid-operation: 3 outstanding with a held output.
        issue_valid = 1'b1;
        issue_sel = 1'b0; tick();
        issue_sel = 1'b0; tick();
        issue_sel = 1'b1; tick();
        issue_sel = 1'b0; tick();
        issue_valid = 1'b0;
        s0_resp_ready = 1'b0;
        m0_resp_valid = 1'b1; m0_resp_data = 32'h77;
        tick();
        m0_resp_valid = 1'b0;
        check("mid_pre_outst", outstanding, 3);
        check("mid_pre_valid", s0_resp_valid, 1);
        rst = 1'b1;
        m0_resp_valid = 1'b1; m1_resp_valid = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("mid_valid", s0_resp_valid, 0);
        check("mid_data",  s0_resp_data, 0);
        check("mid_outst", outstanding, 0);
        check("mid_full",  order_full, 0);
        check("mid_m0_ready", m0_resp_ready, 0);
        check("mid_m1_ready", m1_resp_ready, 0);
        m0_resp_valid = 1'b0; m1_resp_valid = 1'b0;
        s0_resp_ready = 1'b1;

        // Unexpected-response flag.
`ifdef RD_RESP_ERR_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        do_reset();
        settle();
        check("err_clear", err_unexpected, 0);
        m1_resp_valid = 1'b1; m1_resp_data = 32'hEE;
        tick();
        m1_resp_valid = 1'b0;
        check("err_set", err_unexpected, 64'(err_exp));
        tick(); tick();
        check("err_sticky", err_unexpected, 64'(err_exp));
        do_reset();
        settle();
        check("err_rst", err_unexpected, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
